mult_div_unit: RTL and testbench

- Iterative multiply/divide unit in the execute stage, directly downstream of register_file.
- Operands come straight from Read_Data1/Read_Data2 of register_file.
- Computes MIPS-style MULT/MULTU/DIV/DIVU into Hi/Lo result registers with a start/busy/done handshake.
- Fixed latency for every op keeps hazard control in the pipeline simple.

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mdu_abs_neg.sv | 18 +
 rtl/mult_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// state encodings, datapath width and the divide-by-zero quotient pattern.
package mdu_defs;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ITER = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // Bit 0 of the op selects signed handling, bit 1 selects divide.
  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Combinational conditional two's-complement negate. When neg is set the
// value is inverted and carry_in is added, so a single word uses carry_in=1
// and the upper word of a wider negate takes the lower word's carry.
module mdu_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  // Invert-and-increment when negating, pass through otherwise.
  always_comb begin
    result = (neg ? ~value : value) + {{(WIDTH-1){1'b0}}, neg & carry_in};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit. Every op runs a fixed
// 32-step shift-add or restoring-divide loop on operand magnitudes, followed
// by a single sign-fixup cycle, so results always land 33 cycles after Start.
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Div_By_Zero
);

  import mdu_defs::*;

  localparam int CNT_W = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  state_e           state, state_next;
  logic [CNT_W-1:0] count;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;        // raw dividend, returned as Hi on divide-by-zero
  logic [WIDTH-1:0] b_mag;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] work_hi;    // product upper word / partial remainder
  logic [WIDTH-1:0] work_lo;    // multiplier shifting out / quotient shifting in
  logic             neg_a, neg_b;

  // Operand magnitudes, taken only for signed ops.
  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign in_neg_a = Op[0] & Operand_A[WIDTH-1];
  assign in_neg_b = Op[0] & Operand_B[WIDTH-1];

  mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .neg      (in_neg_a),
    .carry_in (1'b1),
    .value    (Operand_A),
    .result   (a_mag_in)
  );

  mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .neg      (in_neg_b),
    .carry_in (1'b1),
    .value    (Operand_B),
    .result   (b_mag_in)
  );

  // One iteration step: shift-add for multiply, trial subtract for divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_borrow;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_mag} : '0);
    div_shift  = {work_hi, work_lo[WIDTH-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, b_mag};
    div_borrow = |div_diff[WIDTH+1:WIDTH];
    step_hi    = work_hi;
    step_lo    = work_lo;
    if (op_is_div(op_q)) begin
      if (div_borrow) begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end
  end

  // Sign fixup. For multiply the two halves form one 64-bit negate: the
  // carry out of ~lo + 1 is set exactly when lo is zero, and feeds the upper
  // half. For divide the halves negate independently (quotient by sign
  // difference, remainder by dividend sign).
  logic             is_div, sign_diff, lo_neg, hi_neg, hi_cin, div0;
  logic [WIDTH-1:0] fix_hi, fix_lo, hi_res, lo_res;

  always_comb begin
    is_div    = op_is_div(op_q);
    sign_diff = op_is_signed(op_q) & (neg_a ^ neg_b);
    lo_neg    = sign_diff;
    hi_neg    = is_div ? (op_is_signed(op_q) & neg_a) : sign_diff;
    hi_cin    = is_div ? 1'b1 : (work_lo == '0);
    div0      = is_div & (b_mag == '0);
    hi_res    = div0 ? a_q : fix_hi;
    lo_res    = div0 ? DIV0_QUOTIENT : fix_lo;
  end

  mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_lo (
    .neg      (lo_neg),
    .carry_in (1'b1),
    .value    (work_lo),
    .result   (fix_lo)
  );

  mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_hi (
    .neg      (hi_neg),
    .carry_in (hi_cin),
    .value    (work_hi),
    .result   (fix_hi)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Busy decode.
  always_comb begin
    state_next = state;
    Busy       = 1'b1;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) state_next = S_ITER;
      end
      S_ITER: if (count == LAST_ITER) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: begin
        Busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count       <= '0;
      op_q        <= OP_MULTU;
      a_q         <= '0;
      b_mag       <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      Hi          <= '0;
      Lo          <= '0;
      Div_By_Zero <= 1'b0;
      Done        <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q    <= op_e'(Op);
            a_q     <= Operand_A;
            b_mag   <= b_mag_in;
            neg_a   <= in_neg_a;
            neg_b   <= in_neg_b;
            work_hi <= '0;
            work_lo <= a_mag_in;
            count   <= '0;
          end
        end
        S_ITER: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          count   <= count + 1'b1;
        end
        S_FIX: begin
          Hi          <= hi_res;
          Lo          <= lo_res;
          Div_By_Zero <= div0;
          Done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of ops with hand-computed Hi/Lo,
// plus sequences for ignored Start, back-to-back issue and mid-op reset.
module tb_mult_div_unit;

  import mdu_defs::*;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Operand_A, Operand_B;
  logic        Busy, Done, Div_By_Zero;
  logic [31:0] Hi, Lo;

  int passed = 0;
  int total  = 0;

  always #5 Clock = ~Clock;

  mult_div_unit #(.WIDTH(32), .ITERATIONS(32)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Op          (Op),
    .Operand_A   (Operand_A),
    .Operand_B   (Operand_B),
    .Busy        (Busy),
    .Done        (Done),
    .Hi          (Hi),
    .Lo          (Lo),
    .Div_By_Zero (Div_By_Zero)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issue an op at the next edge, then scramble the inputs to prove latching.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op = op;
    Operand_A = a;
    Operand_B = b;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Op = 2'($urandom_range(0, 3));
    Operand_A = $urandom;
    Operand_B = $urandom;
  endtask

  // Count edges until Done (bounded); mid-flight, Hi/Lo must still hold.
  task automatic wait_done(input logic [31:0] hold_hi, input logic [31:0] hold_lo, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge Clock);
      #1;
      lat++;
      if (lat == 16) begin
        check("hold_hi", Hi, hold_hi);
        check("hold_lo", Lo, hold_lo);
      end
      if (Done) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          dones;
    logic [31:0] prev_hi, prev_lo;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{OP_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{OP_DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[11] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[13] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    Reset_n = 1'b0;
    Start = 1'b0;
    Op = 2'b00;
    Operand_A = '0;
    Operand_B = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_hi", Hi, 32'd0);
    check("reset_lo", Lo, 32'd0);
    check("reset_dbz", 32'(Div_By_Zero), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    prev_hi = '0;
    prev_lo = '0;
    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 32'(Busy), 32'd1);
      wait_done(prev_hi, prev_lo, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("v%0d_busy_at_done", i), 32'(Busy), 32'd0);
      check($sformatf("v%0d_hi", i), Hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), Lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), 32'(Div_By_Zero), 32'(vecs[i].dbz));
      @(posedge Clock);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(Done), 32'd0);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // Start pulsed at cycle 10 of a MULTU is ignored.
    launch(OP_MULTU, 32'd5, 32'd5);
    repeat (9) @(posedge Clock);
    #1;
    Start = 1'b1;
    Op = OP_DIVU;
    Operand_A = 32'd9;
    Operand_B = 32'd3;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    wait_done(prev_hi, prev_lo, lat);
    check("ignored_latency", 32'(lat + 10), 32'd33);
    check("ignored_lo", Lo, 32'd25);
    check("ignored_hi", Hi, 32'd0);

    // Start in the Done cycle is accepted immediately.
    launch(OP_DIVU, 32'd1000, 32'd3);
    check("b2b_busy", 32'(Busy), 32'd1);
    wait_done(32'd0, 32'd25, lat);
    check("b2b_latency", 32'(lat), 32'd33);
    check("b2b_lo", Lo, 32'd333);
    check("b2b_hi", Hi, 32'd1);

    // Asynchronous reset mid-iteration discards the op.
    @(posedge Clock);
    #1;
    launch(OP_DIVU, 32'd77, 32'd4);
    repeat (11) @(posedge Clock);
    #3;
    Reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge Clock);
      #1;
      if (Done) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);
    check("rst_idle", 32'(Busy), 32'd0);
    launch(OP_DIVU, 32'd50, 32'd5);
    wait_done(32'd0, 32'd0, lat);
    check("post_rst_latency", 32'(lat), 32'd33);
    check("post_rst_lo", Lo, 32'd10);
    check("post_rst_hi", Hi, 32'd0);
    check("post_rst_dbz", 32'(Div_By_Zero), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
